// File: rtl/aes_mode_sequencer_if.sv
// Request-side and AES-core-side signals of the mode sequencer, bundled for port connection.
// The slave modport is the sequencer's view; the master modport is the surrounding environment's view.
interface aes_mode_sequencer_if #(
    parameter int N_BLOCKS = 4
);
    logic                    start;
    logic                    cntrl;
    logic [127:0]            key;
    logic [127:0]            counter;
    logic [127:0]            iv;
    logic [N_BLOCKS*128-1:0] data;
    logic [N_BLOCKS*128-1:0] out;
    logic                    done;
    logic                    busy;
    logic                    core_start;
    logic [127:0]            core_key;
    logic [127:0]            core_in;
    logic [127:0]            core_out;
    logic                    core_done;

    modport slave (
        input  start, cntrl, key, counter, iv, data, core_out, core_done,
        output out, done, busy, core_start, core_key, core_in
    );

    modport master (
        output start, cntrl, key, counter, iv, data, core_out, core_done,
        input  out, done, busy, core_start, core_key, core_in
    );
endinterface

// File: rtl/aes_mode_sequencer.sv
// Drives a single-block AES-128 encrypt core over N_BLOCKS blocks in CTR (cntrl=0) or CBC (cntrl=1) mode.
// All request inputs are latched on the accepted start; every output is a register.
module aes_mode_sequencer #(
    parameter int N_BLOCKS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    aes_mode_sequencer_if.slave  bus
);
    localparam int W     = N_BLOCKS * 128;
    localparam int BLK_W = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(N_BLOCKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_mode;
    logic [127:0]       r_key;
    logic [127:0]       r_ctr;
    logic [127:0]       r_chain;
    logic [W-1:0]       r_data;
    logic [BLK_W-1:0]   r_blk;
    logic [W-1:0]       r_out;
    logic               r_done;
    logic               r_busy;
    logic               r_core_start;
    logic [127:0]       r_core_in;
    logic [127:0]       w_core_in_next;
    logic [BLK_W-1:0]   w_next_blk;
    logic               w_last;

    assign w_next_blk = r_blk + BLK_W'(1);
    assign w_last     = (r_blk == LAST_BLK);

    // Next state, plus the core input for the block about to be issued (prepared on the edge into ISSUE).
    always_comb begin
        w_next_state   = r_state;
        w_core_in_next = r_core_in;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state   = ST_ISSUE;
                    w_core_in_next = bus.cntrl ? (bus.data[127:0] ^ bus.iv) : bus.counter;
                end else begin
                    w_next_state   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.core_done) begin
                    if (w_last) begin
                        w_next_state = ST_FIN;
                    end else begin
                        w_next_state   = ST_ISSUE;
                        // The chain for CBC is this block's result, still only on core_out this cycle.
                        w_core_in_next = r_mode ? (r_data[{w_next_blk, 7'd0} +: 128] ^ bus.core_out)
                                                : (r_ctr + 128'd1);
                    end
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_FIN: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register, request latches, per-block result update and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_mode       <= 1'b0;
            r_key        <= 128'd0;
            r_ctr        <= 128'd0;
            r_chain      <= 128'd0;
            r_data       <= '0;
            r_blk        <= '0;
            r_out        <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_core_start <= 1'b0;
            r_core_in    <= 128'd0;
        end else begin
            r_state      <= w_next_state;
            r_busy       <= (w_next_state != ST_IDLE);
            r_done       <= (w_next_state == ST_FIN);
            r_core_start <= (w_next_state == ST_ISSUE);
            r_core_in    <= w_core_in_next;
            if ((r_state == ST_IDLE) && bus.start) begin
                r_mode  <= bus.cntrl;
                r_key   <= bus.key;
                r_ctr   <= bus.counter;
                r_chain <= bus.iv;
                r_data  <= bus.data;
                r_blk   <= '0;
                r_out   <= '0;
            end else if ((r_state == ST_WAIT) && bus.core_done) begin
                if (r_mode) begin
                    r_out[{r_blk, 7'd0} +: 128] <= bus.core_out;
                    r_chain                     <= bus.core_out;
                end else begin
                    r_out[{r_blk, 7'd0} +: 128] <= bus.core_out ^ r_data[{r_blk, 7'd0} +: 128];
                    r_ctr                       <= r_ctr + 128'd1;
                end
                if (!w_last) begin
                    r_blk <= w_next_blk;
                end
            end
        end
    end

    assign bus.out        = r_out;
    assign bus.done       = r_done;
    assign bus.busy       = r_busy;
    assign bus.core_start = r_core_start;
    assign bus.core_key   = r_key;
    assign bus.core_in    = r_core_in;
endmodule

// File: tb/tb_aes_mode_sequencer.sv
// Bench for aes_mode_sequencer: AES-128 reference core with programmable latency, a request-level
// expectation model compared every cycle, and directed scenarios with NIST SP800-38A vectors.
module tb_aes_mode_sequencer;
    localparam int NB = 4;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CTR0 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [NB*128-1:0] PT = {128'hf69f2445df4f9b17ad2b417be66c3710, 128'h30c81c46a35ce411e5fbc1191a0a52ef,
                                        128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h6bc1bee22e409f96e93d7e117393172a};
    localparam logic [NB*128-1:0] CTR_EXP = {128'h1e031dda2fbe03d1792170a0f3009cee, 128'h5ae4df3edbd5d35e5b4f09020db03eab,
                                             128'h9806f66b7970fdff8617187bb9fffdff, 128'h874d6191b620e3261bef6864990db6ce};
    localparam logic [NB*128-1:0] CBC_EXP = {128'h3ff1caa1681fac09120eca307586e1a7, 128'h73bed6b8e3c1743b7116e69e22229516,
                                             128'h5086cb9b507219ee95db113a917678b2, 128'h7649abac8119b246cee98e9b12e9197d};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_mode_sequencer_if #(.N_BLOCKS(NB)) bus_if ();
    aes_mode_sequencer #(.N_BLOCKS(NB)) dut (.i_clk(clk), .i_rst(rst), .bus(bus_if));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int core_lat = 10;
    logic [127:0] cs_log[$];
    int acc_q[$];
    int done_q[$];
    logic [7:0] sbox_tab [256];

    task automatic chk(input string nm, input logic [NB*128-1:0] act, input logic [NB*128-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                repeat (254) inv = gmul(inv, 8'(x));
            end
            sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [7:0] rk [176];
        logic [7:0] st [16];
        logic [7:0] tmp [16];
        logic [7:0] t0, t1, t2, t3, a0, a1, a2, a3, rc;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) rk[i] = k[127-8*i -: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t0 = rk[4*i-4]; t1 = rk[4*i-3]; t2 = rk[4*i-2]; t3 = rk[4*i-1];
            if (i % 4 == 0) begin
                a0 = t0;
                t0 = sbox_tab[t1] ^ rc; t1 = sbox_tab[t2]; t2 = sbox_tab[t3]; t3 = sbox_tab[a0];
                rc = xt(rc);
            end
            rk[4*i] = rk[4*i-16] ^ t0; rk[4*i+1] = rk[4*i-15] ^ t1;
            rk[4*i+2] = rk[4*i-14] ^ t2; rk[4*i+3] = rk[4*i-13] ^ t3;
        end
        for (int i = 0; i < 16; i++) st[i] = p[127-8*i -: 8] ^ rk[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sbox_tab[st[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) st[rr+4*c] = tmp[rr+4*((c+rr)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // Reference core: samples core_in/core_key on core_start, answers core_lat cycles later.
    initial begin
        logic pend;
        int cnt;
        logic fire;
        logic [127:0] pin;
        logic [127:0] pkey;
        pend = 1'b0; cnt = 0; pin = 128'd0; pkey = 128'd0;
        bus_if.core_done = 1'b0;
        bus_if.core_out = 128'd0;
        forever begin
            @(posedge clk);
            fire = 1'b0;
            if (bus_if.core_start === 1'b1) begin
                pend = 1'b1; cnt = core_lat; pin = bus_if.core_in; pkey = bus_if.core_key;
            end
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    fire = 1'b1;
                    pend = 1'b0;
                end
            end
            #1;
            bus_if.core_done = fire;
            if (fire) bus_if.core_out = aes_enc(pkey, pin);
        end
    end

    // Request-level model: on acceptance, derive every core input, the final output and the timeline.
    initial begin
        logic m_act;
        int m_t, m_done_t, m_L, blk;
        logic m_mode;
        logic [127:0] m_key, m_chain, m_c;
        logic [127:0] m_in [NB];
        logic [NB*128-1:0] m_out, m_hold, m_data;
        logic exp_cs, exp_done;
        m_act = 1'b0; m_t = 0; m_done_t = 0; m_L = 1; m_hold = '0; m_out = '0; m_key = 128'd0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_act = 1'b0;
                m_hold = '0;
            end else if (m_act) begin
                if (m_t == m_done_t) begin
                    m_act = 1'b0;
                    m_hold = m_out;
                end else begin
                    m_t++;
                end
            end else if (bus_if.start === 1'b1) begin
                m_act = 1'b1; m_t = 1; m_L = core_lat; m_done_t = 1 + NB * (m_L + 1);
                m_mode = bus_if.cntrl; m_key = bus_if.key; m_data = bus_if.data; m_chain = bus_if.iv;
                for (int k = 0; k < NB; k++) begin
                    if (m_mode) begin
                        m_in[k] = m_data[128*k +: 128] ^ m_chain;
                        m_chain = aes_enc(m_key, m_in[k]);
                        m_out[128*k +: 128] = m_chain;
                    end else begin
                        m_in[k] = bus_if.counter + 128'(k);
                        m_c = aes_enc(m_key, m_in[k]);
                        m_out[128*k +: 128] = m_c ^ m_data[128*k +: 128];
                    end
                end
                acc_q.push_back(cyc);
            end
            cyc++;
            @(negedge clk);
            exp_done = m_act && (m_t == m_done_t);
            exp_cs = m_act && (m_t < m_done_t) && (((m_t - 1) % (m_L + 1)) == 0);
            chk("busy", {511'd0, bus_if.busy}, {511'd0, m_act});
            chk("done", {511'd0, bus_if.done}, {511'd0, exp_done});
            chk("core_start", {511'd0, bus_if.core_start}, {511'd0, exp_cs});
            if (m_act && (m_t < m_done_t)) begin
                blk = (m_t - 1) / (m_L + 1);
                chk("core_in", {384'd0, bus_if.core_in}, {384'd0, m_in[blk]});
                chk("core_key", {384'd0, bus_if.core_key}, {384'd0, m_key});
            end
            if (exp_done) chk("out_at_done", bus_if.out, m_out);
            if (!m_act) chk("out_idle", bus_if.out, m_hold);
            if (bus_if.core_start === 1'b1) cs_log.push_back(bus_if.core_in);
            if (bus_if.done === 1'b1) done_q.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic mode, input logic [127:0] ctr, input int lat);
        core_lat = lat;
        bus_if.cntrl = mode; bus_if.key = KEY; bus_if.counter = ctr; bus_if.iv = IV0; bus_if.data = PT;
        bus_if.start = 1'b1;
        tick(1);
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int limit);
        int n;
        n = 0;
        while (bus_if.done !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        chk(nm, {511'd0, bus_if.done}, {511'd0, 1'b1});
    endtask

    initial begin
        int s0, d0, a0, dn;
        init_sbox();
        bus_if.start = 1'b0; bus_if.cntrl = 1'b0; bus_if.key = 128'd0; bus_if.counter = 128'd0;
        bus_if.iv = 128'd0; bus_if.data = '0;
        chk("aes_model_vec", {384'd0, aes_enc(KEY, CTR0)}, {384'd0, 128'hec8cdf7398607cb0f2d21675ea9ea1e4});
        tick(3);
        rst = 1'b0;
        chk("reset_out", bus_if.out, '0);
        chk("reset_busy", {511'd0, bus_if.busy}, 512'd0);
        tick(2);

        // 1: CTR, L=10
        start_req(1'b0, CTR0, 10);
        wait_done("s1_done_seen", 200);
        chk("s1_out", bus_if.out, CTR_EXP);
        tick(2);
        chk("s1_latency", 512'(done_q[done_q.size()-1] - acc_q[acc_q.size()-1]), 512'd45);
        chk("s1_out_held", bus_if.out, CTR_EXP);

        // 2: CBC, L=3
        start_req(1'b1, CTR0, 3);
        wait_done("s2_done_seen", 200);
        chk("s2_out", bus_if.out, CBC_EXP);
        tick(2);
        chk("s2_latency", 512'(done_q[done_q.size()-1] - acc_q[acc_q.size()-1]), 512'd17);

        // 3: counter wrap
        s0 = cs_log.size();
        start_req(1'b0, {128{1'b1}}, 2);
        wait_done("s3_done_seen", 200);
        tick(2);
        chk("s3_cs_count", 512'(cs_log.size() - s0), 512'd4);
        chk("s3_core_in_2nd", {384'd0, cs_log[s0+1]}, 512'd0);
        chk("s3_core_in_3rd", {384'd0, cs_log[s0+2]}, 512'd1);

        // 4: input churn and start re-pulses mid-request (L=20 keeps cycles 29 and 59 inside it)
        s0 = cs_log.size(); d0 = done_q.size();
        start_req(1'b0, CTR0, 20);
        tick(28);
        bus_if.cntrl = ~bus_if.cntrl; bus_if.key = ~KEY; bus_if.data = ~PT; bus_if.counter = 128'd5; bus_if.start = 1'b1;
        tick(1);
        bus_if.start = 1'b0;
        tick(29);
        bus_if.cntrl = ~bus_if.cntrl; bus_if.iv = 128'd7; bus_if.start = 1'b1;
        tick(1);
        bus_if.start = 1'b0;
        wait_done("s4_done_seen", 200);
        chk("s4_out", bus_if.out, CTR_EXP);
        tick(20);
        chk("s4_done_count", 512'(done_q.size() - d0), 512'd1);
        chk("s4_cs_count", 512'(cs_log.size() - s0), 512'd4);

        // 5: reset while waiting on block 2, late core_done must be ignored
        d0 = done_q.size();
        start_req(1'b0, CTR0, 10);
        tick(25);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("s5_busy_after_rst", {511'd0, bus_if.busy}, 512'd0);
        chk("s5_out_after_rst", bus_if.out, '0);
        tick(10);
        chk("s5_busy_late", {511'd0, bus_if.busy}, 512'd0);
        chk("s5_out_late", bus_if.out, '0);
        chk("s5_no_done", 512'(done_q.size() - d0), 512'd0);
        start_req(1'b1, CTR0, 3);
        wait_done("s5_done_seen", 200);
        chk("s5_cbc_out", bus_if.out, CBC_EXP);
        tick(3);

        // 6: L=1, start held high -> back-to-back requests
        a0 = acc_q.size(); d0 = done_q.size();
        core_lat = 1;
        bus_if.cntrl = 1'b0; bus_if.key = KEY; bus_if.counter = CTR0; bus_if.data = PT; bus_if.start = 1'b1;
        dn = 0;
        for (int n = 0; n < 60 && dn < 3; n++) begin
            tick(1);
            if (bus_if.done === 1'b1) dn++;
        end
        bus_if.start = 1'b0;
        chk("s6_done_count_seen", 512'(dn), 512'd3);
        tick(3);
        chk("s6_req_count", 512'(acc_q.size() - a0), 512'd3);
        chk("s6_lat0", 512'(done_q[d0] - acc_q[a0]), 512'd9);
        chk("s6_gap0", 512'(acc_q[a0+1] - done_q[d0]), 512'd1);
        chk("s6_lat1", 512'(done_q[d0+1] - acc_q[a0+1]), 512'd9);
        chk("s6_gap1", 512'(acc_q[a0+2] - done_q[d0+1]), 512'd1);
        chk("s6_out", bus_if.out, CTR_EXP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
